shift_register_bank: RTL and testbench

Parametrised successor to the two-register A/B shift unit used by the serial datapath. Holds NUM_REGS registers of WIDTH bits each, with per-register parallel load. Registers shift either independently or chained into one long register, in logical, arithmetic or rotate mode. Adds an FSM-sequenced burst shift of N steps with a Busy/Done handshake, so the controller no longer has to count shifts.

---
 rtl/shift_bank_pkg.sv | 26 ++
 rtl/shift_reg_slice.sv | 40 ++++
 rtl/shift_register_bank.sv | 187 ++++++++++++++++++
 tb/tb_shift_register_bank.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_bank_pkg.sv
// Shared types for the shift register bank: shift modes, burst FSM states
// and the decoder from the raw 2-bit Mode input.
package shift_bank_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'd0,
    MODE_ASR = 2'd1,
    MODE_ROR = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The unused encoding 2'b11 behaves as a logical shift.
  function automatic mode_t decode_mode(input logic [1:0] mode);
    case (mode)
      2'b01:   return MODE_ASR;
      2'b10:   return MODE_ROR;
      default: return MODE_LSR;
    endcase
  endfunction

endpackage

// File: rtl/shift_reg_slice.sv
// One WIDTH-bit register of the bank: parallel load has priority over shift,
// otherwise hold. The fill bit is routed in by the parent.
module shift_reg_slice
  import shift_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic             fill,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             lsb,
  output logic             msb
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end else if (shift) begin
      if (dir) begin
        q_reg <= {q_reg[WIDTH-2:0], fill};
      end else begin
        q_reg <= {fill, q_reg[WIDTH-1:1]};
      end
    end
  end

  assign q   = q_reg;
  assign lsb = q_reg[0];
  assign msb = q_reg[WIDTH-1];

endmodule

// File: rtl/shift_register_bank.sv
// Bank of NUM_REGS shift registers with chaining and an FSM-sequenced burst.
// Optional macro BIDIR_SHIFT_EN adds a Dir input for left shifts.
module shift_register_bank
  import shift_bank_pkg::*;
#(
  parameter int NUM_REGS = 2,
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 5
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REGS-1:0]       Ld,
  input  logic [WIDTH-1:0]          D,
  input  logic                      Shift_En,
  input  logic                      Start,
  input  logic [CNT_W-1:0]          Shift_Count,
  input  logic [1:0]                Mode,
  input  logic                      Chain,
`ifdef BIDIR_SHIFT_EN
  input  logic                      Dir,
`endif
  input  logic [NUM_REGS-1:0]       Serial_In,
  output logic [NUM_REGS-1:0]       Serial_Out,
  output logic [NUM_REGS*WIDTH-1:0] Data_Out,
  output logic                      Busy,
  output logic                      Done
);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  mode_t                mode_reg, mode_next;
  logic                 chain_reg, chain_next;
  logic                 do_shift;
  logic [NUM_REGS-1:0]  load_vec;
  logic [NUM_REGS-1:0]  lsb, msb, fill;
  mode_t                sel_mode;
  logic                 sel_chain;
  logic                 sel_dir;

  // In IDLE a single-step shift uses the live controls; a burst uses the
  // copies latched on Start so mid-burst changes have no effect.
  assign sel_mode  = (state_reg == IDLE) ? decode_mode(Mode) : mode_reg;
  assign sel_chain = (state_reg == IDLE) ? Chain : chain_reg;

`ifdef BIDIR_SHIFT_EN
  logic dir_reg, dir_next, so_dir_reg;

  assign sel_dir = (state_reg == IDLE) ? Dir : dir_reg;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dir_reg    <= 1'b0;
      so_dir_reg <= 1'b0;
    end else begin
      dir_reg    <= dir_next;
      so_dir_reg <= sel_dir;
    end
  end

  always_comb begin
    dir_next = dir_reg;
    if (state_reg == IDLE && Ld == '0 && Start) begin
      dir_next = Dir;
    end
  end

  assign Serial_Out = so_dir_reg ? msb : lsb;
`else
  assign sel_dir    = 1'b0;
  assign Serial_Out = lsb;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mode_reg  <= MODE_LSR;
      chain_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      chain_reg <= chain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    chain_next = chain_reg;
    do_shift   = 1'b0;
    load_vec   = '0;
    case (state_reg)
      IDLE: begin
        if (Ld != '0) begin
          load_vec = Ld;
        end else if (Start) begin
          mode_next  = decode_mode(Mode);
          chain_next = Chain;
          if (Shift_Count == '0) begin
            state_next = DONE;
          end else begin
            cnt_next   = Shift_Count;
            state_next = SHIFT;
          end
        end else if (Shift_En) begin
          do_shift = 1'b1;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign Busy = (state_reg == SHIFT);
  assign Done = (state_reg == DONE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_slice
      logic             own_r, fill_r;
      logic [WIDTH-1:0] q_slice;

      always_comb begin
        case (sel_mode)
          MODE_ASR: own_r = msb[gi];
          MODE_ROR: own_r = lsb[gi];
          default:  own_r = Serial_In[gi];
        endcase
      end

      // Register 0 heads a right-shifting chain; the rest take their
      // upstream neighbour's LSB regardless of mode.
      if (gi == 0) begin : g_head_r
        assign fill_r = (sel_chain && sel_mode == MODE_ROR) ? lsb[NUM_REGS-1] : own_r;
      end else begin : g_tail_r
        assign fill_r = sel_chain ? lsb[gi-1] : own_r;
      end

`ifdef BIDIR_SHIFT_EN
      logic own_l, fill_l;

      assign own_l = (sel_mode == MODE_ROR) ? msb[gi] : Serial_In[gi];

      if (gi == NUM_REGS - 1) begin : g_head_l
        assign fill_l = sel_chain ? ((sel_mode == MODE_ROR) ? msb[0] : Serial_In[0]) : own_l;
      end else begin : g_tail_l
        assign fill_l = sel_chain ? msb[gi+1] : own_l;
      end

      assign fill[gi] = sel_dir ? fill_l : fill_r;
`else
      assign fill[gi] = fill_r;
`endif

      shift_reg_slice #(
        .WIDTH (WIDTH)
      ) u_slice (
        .clk     (Clk),
        .reset_n (Reset_n),
        .load    (load_vec[gi]),
        .shift   (do_shift),
        .dir     (sel_dir),
        .fill    (fill[gi]),
        .d       (D),
        .q       (q_slice),
        .lsb     (lsb[gi]),
        .msb     (msb[gi])
      );

      assign Data_Out[(NUM_REGS-gi)*WIDTH-1 -: WIDTH] = q_slice;
    end
  endgenerate

endmodule

// File: tb/tb_shift_register_bank.sv
// Self-checking bench for shift_register_bank (2 x 8-bit, right shift build):
// directed steps followed by randomized operations against a bank model.
module tb_shift_register_bank;

  localparam int NR = 2;
  localparam int W  = 8;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   ld = '0;
  logic [W-1:0]    d = '0;
  logic            shift_en = 1'b0;
  logic            start = 1'b0;
  logic [CW-1:0]   shift_count = '0;
  logic [1:0]      mode = 2'b00;
  logic            chain = 1'b0;
  logic [NR-1:0]   serial_in = '0;
  logic [NR-1:0]   serial_out;
  logic [NR*W-1:0] data_out;
  logic            busy;
  logic            done;

  int errors = 0;
  int checks = 0;

  // Bank image in Data_Out layout: register 0 in [15:8], register 1 in [7:0].
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  shift_register_bank #(
    .NUM_REGS (NR),
    .WIDTH    (W),
    .CNT_W    (CW)
  ) dut (
    .Clk         (clk),
    .Reset_n     (reset_n),
    .Ld          (ld),
    .D           (d),
    .Shift_En    (shift_en),
    .Start       (start),
    .Shift_Count (shift_count),
    .Mode        (mode),
    .Chain       (chain),
    .Serial_In   (serial_in),
    .Serial_Out  (serial_out),
    .Data_Out    (data_out),
    .Busy        (busy),
    .Done        (done)
  );

  function automatic logic [7:0] shr8(logic [7:0] r, logic [1:0] m, logic s);
    logic f;
    f = (m == 2'b01) ? r[7] : (m == 2'b10) ? r[0] : s;
    return {f, r[7:1]};
  endfunction

  // Chain mode treats the bank as one 16-bit register shifted right.
  function automatic logic [15:0] model_shift(logic [15:0] v, logic [1:0] m, logic c, logic [1:0] s);
    logic f;
    if (c) begin
      f = (m == 2'b01) ? v[15] : (m == 2'b10) ? v[0] : s[0];
      return {f, v[15:1]};
    end
    return {shr8(v[15:8], m, s[0]), shr8(v[7:0], m, s[1])};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_bank(string tag);
    check({tag, "_data"}, 32'(data_out), 32'(exp_v));
    check({tag, "_sout"}, 32'(serial_out), 32'({exp_v[0], exp_v[8]}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(int n, logic [1:0] m, logic c, bit inject);
    shift_count = CW'(n);
    mode  = m;
    chain = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check("burst_busy", 32'(busy), 32'd1);
      check("burst_done_low", 32'(done), 32'd0);
      check_bank("burst_step");
      serial_in = NR'($urandom);
      mode      = 2'($urandom);
      chain     = 1'($urandom);
      if (inject && k == 1) begin
        start = 1'b1;
        ld    = 2'b11;
        d     = 8'hFF;
      end else begin
        start = 1'b0;
        ld    = '0;
      end
      tick();
      exp_v = model_shift(exp_v, m, c, serial_in);
    end
    start = 1'b0;
    ld    = '0;
    check("burst_end_busy", 32'(busy), 32'd0);
    check("burst_end_done", 32'(done), 32'd1);
    check_bank("burst_end");
    tick();
    check("burst_done_pulse", 32'(done), 32'd0);
    check_bank("burst_after");
    $display("burst n=%0d mode=%0d chain=%0d -> data=%04h", n, m, c, data_out);
  endtask

  initial begin
    exp_v = 16'h0000;

    // Step 1: load, then a reset edge clears everything.
    tick();
    tick();
    reset_n = 1'b1;
    ld = 2'b11;
    d  = 8'h77;
    tick();
    ld = '0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_data", 32'(data_out), 32'h0000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sout", 32'(serial_out), 32'd0);
    $display("reset -> data=%04h", data_out);

    // Step 2: two single-register loads, then one independent logical shift.
    ld = 2'b01; d = 8'hA5; tick(); exp_v[15:8] = 8'hA5;
    ld = 2'b10; d = 8'h3C; tick(); exp_v[7:0]  = 8'h3C;
    ld = '0;
    check("load_data", 32'(data_out), 32'hA53C);
    check("load_sout", 32'(serial_out), 32'b01);
    chain = 1'b0; mode = 2'b00; serial_in = 2'b00; shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
    exp_v = model_shift(exp_v, 2'b00, 1'b0, 2'b00);
    check("lsr_data", 32'(data_out), 32'h521E);
    check_bank("lsr");
    $display("single shift -> data=%04h", data_out);

    // Step 3: chained rotate burst of 4.
    ld = 2'b01; d = 8'h81; tick();
    ld = 2'b10; d = 8'h00; tick();
    ld = '0;
    exp_v = 16'h8100;
    run_burst(4, 2'b10, 1'b1, 1'b0);
    check("ror_chain", 32'(data_out), 32'h0810);

    // Step 4: chained arithmetic burst with ignored mid-burst Start and Ld.
    ld = 2'b01; d = 8'h80; tick();
    ld = 2'b10; d = 8'h00; tick();
    ld = '0;
    exp_v = 16'h8000;
    run_burst(3, 2'b01, 1'b1, 1'b1);
    check("asr_chain", 32'(data_out), 32'hF000);

    // Step 5: zero-length burst.
    run_burst(0, 2'b00, 1'b0, 1'b0);
    check("zero_burst", 32'(data_out), 32'hF000);

    // Step 6: reset at the second shift edge of a burst of 4.
    shift_count = 5'd4; mode = 2'b00; chain = 1'b0; serial_in = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_v = 16'h0000;
    check("abort_data", 32'(data_out), 32'h0000);
    check("abort_busy_low", 32'(busy), 32'd0);
    for (int k = 0; k < 6; k++) begin
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      tick();
    end
    $display("aborted burst -> data=%04h", data_out);

    // Randomized operations.
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op == 0) begin
        ld = NR'($urandom_range(1, 3));
        d = W'($urandom);
        shift_en = 1'($urandom);
        start = 1'($urandom);
        shift_count = CW'($urandom_range(1, 5));
        tick();
        if (ld[0]) exp_v[15:8] = d;
        if (ld[1]) exp_v[7:0]  = d;
        ld = '0; shift_en = 1'b0; start = 1'b0;
        check("rnd_load_busy", 32'(busy), 32'd0);
        check_bank("rnd_load");
        $display("load ld=%0b d=%02h -> data=%04h", ld, d, data_out);
      end else if (op == 1) begin
        mode = 2'($urandom);
        chain = 1'($urandom);
        serial_in = NR'($urandom);
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        exp_v = model_shift(exp_v, mode, chain, serial_in);
        check_bank("rnd_shift");
        $display("shift mode=%0d chain=%0d sin=%0b -> data=%04h", mode, chain, serial_in, data_out);
      end else begin
        run_burst($urandom_range(0, 6), 2'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
